// File: rtl/imm_encoder_rv32.sv
// RV32 immediate encoder: packs I/S/SB/J fields into an instruction word, flags out-of-range immediates.
// Latency 1 cycle through a 2-entry FIFO; in_ready depends only on registered occupancy.
module imm_encoder_rv32 #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ImmSel,
  input  logic [31:0]      imm,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [6:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e           state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             live_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [32:0]      mem_q [2];

  logic        push, pop;
  logic [31:0] enc;
  logic        enc_err;

  always_comb begin
    enc     = 32'h0;
    enc_err = 1'b0;
    unique case (ImmSel)
      2'b00: begin
        enc     = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      2'b01: begin
        enc     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      2'b10: begin
        enc     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      default: begin
        enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
    endcase
  end

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = live_q && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_err, instr} = mem_q[rd_ptr_q];
  assign err_count = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (push && enc_err && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_W'(1);
    unique case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      live_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      live_q    <= 1'b1;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Payload storage needs no reset: it is only observed while out_valid=1.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {enc_err, enc};
  end

endmodule

// File: tb/tb_imm_encoder_rv32.sv
// Bench for imm_encoder_rv32: arithmetic reference model with a per-cycle compare, plus literal vectors.
module tb_imm_encoder_rv32;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       ImmSel = '0;
  logic [31:0]      imm = '0;
  logic [4:0]       rs1 = '0, rs2 = '0, rd = '0;
  logic [2:0]       funct3 = '0;
  logic [6:0]       opcode = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      instr;
  logic             out_err;
  logic [ERR_W-1:0] err_count;

  imm_encoder_rv32 #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSel(ImmSel), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference encoding from plain integer ranges and shift/mask field placement.
  function automatic logic [32:0] model_enc(input logic [1:0] s, input logic [31:0] im,
                                            input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] d, input logic [2:0] f,
                                            input logic [6:0] op);
    longint      v;
    logic [31:0] w, ua, ub, ud, uf, uo;
    logic        bad;
    v  = longint'($signed(im));
    ua = 32'(a); ub = 32'(b); ud = 32'(d); uf = 32'(f); uo = 32'(op);
    w  = '0;
    bad = 1'b0;
    case (s)
      2'd0: begin
        bad = (v < -2048) || (v > 2047);
        w = ((im & 32'hFFF) << 20) | (ua << 15) | (uf << 12) | (ud << 7) | uo;
      end
      2'd1: begin
        bad = (v < -2048) || (v > 2047);
        w = (((im >> 5) & 32'h7F) << 25) | (ub << 20) | (ua << 15) | (uf << 12)
          | ((im & 32'h1F) << 7) | uo;
      end
      2'd2: begin
        bad = (v < -4096) || (v > 4095) || (im[0] == 1'b1);
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (ub << 20)
          | (ua << 15) | (uf << 12) | (((im >> 1) & 32'hF) << 8)
          | (((im >> 11) & 32'h1) << 7) | uo;
      end
      default: begin
        bad = (v < -1048576) || (v > 1048575) || (im[0] == 1'b1);
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
          | (ud << 7) | uo;
      end
    endcase
    return {bad, w};
  endfunction

  logic [32:0] mq[$];
  logic [32:0] seen[$];
  int          seen_cyc[$];
  int          acc_cyc[$];
  int          m_err = 0;
  bit          m_en = 1'b0;
  bit          m_rdy = 1'b0;
  bit          acc_f = 1'b0;
  bit          pop_f = 1'b0;
  logic [32:0] pend = '0;
  bit          stall_q = 1'b0;
  logic [32:0] stall_w = '0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    acc_f = 1'b0;
    pop_f = 1'b0;
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      stall_q = 1'b0;
    end else begin
      m_rdy = m_en && (mq.size() < 2);
      chk("in_ready", 64'(in_ready), 64'(m_rdy));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("err_count", 64'(err_count), 64'(m_err));
      if (out_valid && mq.size() != 0)
        chk("head_word", 64'({out_err, instr}), 64'(mq[0]));
      if (stall_q)
        chk("stall_hold", 64'({out_valid, out_err, instr}), 64'({1'b1, stall_w}));
      acc_f = in_valid && m_rdy;
      if (acc_f) begin
        pend = model_enc(ImmSel, imm, rs1, rs2, rd, funct3, opcode);
        acc_cyc.push_back(cyc);
      end
      pop_f = (mq.size() != 0) && out_ready;
      if (pop_f) begin
        seen.push_back({out_err, instr});
        seen_cyc.push_back(cyc);
      end
      stall_q = out_valid && !out_ready;
      stall_w = {out_err, instr};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_err = 0;
      m_en  = 1'b0;
      acc_f = 1'b0;
      pop_f = 1'b0;
    end else begin
      if (pop_f) void'(mq.pop_front());
      if (acc_f) begin
        mq.push_back(pend);
        if (pend[32] && m_err < (2**ERR_W - 1)) m_err++;
      end
      m_en = 1'b1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] im, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d, input logic [2:0] f,
                      input logic [6:0] op);
    bit ok;
    ok = 1'b0;
    ImmSel = s; imm = im; rs1 = a; rs2 = b; rd = d; funct3 = f; opcode = op;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_accept: in_ready never rose within 50 cycles, expected accept");
    end
  endtask

  task automatic chk_seen(input string name, input int idx, input logic [32:0] exp);
    if (idx >= seen.size()) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: word %0d never emitted, expected %0h", name, idx, exp);
    end else begin
      chk(name, 64'(seen[idx]), 64'(exp));
    end
  endtask

  int b;

  initial begin
    #1;
    chk("por_in_ready", 64'(in_ready), 64'd0);
    chk("por_out_valid", 64'(out_valid), 64'd0);
    chk("por_err_count", 64'(err_count), 64'd0);
    #12 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // I format, plus first-word latency
    b = seen.size();
    send(2'd0, 32'd4, 5'd10, 5'd0, 5'd13, 3'd0, 7'h13);
    cycles(2);
    chk_seen("I_word", b, {1'b0, 32'h00450693});
    if (seen_cyc.size() > b && acc_cyc.size() > b)
      chk("I_latency", 64'(seen_cyc[b] - acc_cyc[b]), 64'd1);

    // S then J back-to-back; J carries junk in rs1/rs2/funct3
    b = seen.size();
    send(2'd1, 32'd8, 5'd10, 5'd11, 5'd0, 3'd2, 7'h23);
    send(2'd3, 32'd4, 5'd5, 5'd7, 5'd0, 3'd3, 7'h6F);
    cycles(3);
    chk_seen("S_word", b, {1'b0, 32'h00B52423});
    chk_seen("J_word", b + 1, {1'b0, 32'h0040006F});
    if (seen_cyc.size() > b + 1)
      chk("SJ_consecutive", 64'(seen_cyc[b+1] - seen_cyc[b]), 64'd1);

    // SB misaligned
    b = seen.size();
    send(2'd2, 32'd13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h63);
    cycles(2);
    chk_seen("SB_misaligned", b, {1'b1, 32'h00208663});
    chk("SB_err_count", 64'(err_count), 64'd1);

    // I range boundaries
    b = seen.size();
    send(2'd0, 32'h00000800, 5'd0, 5'd0, 5'd1, 3'd0, 7'h13);
    send(2'd0, 32'hFFFFF800, 5'd0, 5'd0, 5'd1, 3'd0, 7'h13);
    cycles(3);
    chk_seen("I_over", b, {1'b1, 32'h80000093});
    chk_seen("I_min", b + 1, {1'b0, 32'h80000093});
    chk("range_err_count", 64'(err_count), 64'd2);

    // Backpressure with three requests
    out_ready = 1'b0;
    b = seen.size();
    fork
      begin
        send(2'd0, 32'd1, 5'd0, 5'd0, 5'd1, 3'd0, 7'h13);
        send(2'd0, 32'd2, 5'd0, 5'd0, 5'd1, 3'd0, 7'h13);
        send(2'd0, 32'd3, 5'd0, 5'd0, 5'd1, 3'd0, 7'h13);
      end
      begin
        cycles(6);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head", 64'({out_valid, instr}), 64'({1'b1, 32'h00100093}));
        out_ready = 1'b1;
      end
    join
    cycles(4);
    chk_seen("bp_w0", b, {1'b0, 32'h00100093});
    chk_seen("bp_w1", b + 1, {1'b0, 32'h00200093});
    chk_seen("bp_w2", b + 2, {1'b0, 32'h00300093});

    // Asynchronous reset with a full FIFO
    out_ready = 1'b0;
    send(2'd0, 32'h00000800, 5'd0, 5'd0, 5'd1, 3'd0, 7'h13);
    send(2'd0, 32'd5, 5'd0, 5'd0, 5'd2, 3'd0, 7'h13);
    cycles(1);
    chk("pre_rst_err_count", 64'(err_count), 64'd3);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_err_count", 64'(err_count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    cycles(2);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    b = seen.size();
    cycles(5);
    chk("no_stale_word", 64'(seen.size()), 64'(b));
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Error counter saturation
    repeat (260) send(2'd2, 32'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h63);
    cycles(3);
    chk("err_saturate", 64'(err_count), 64'(2**ERR_W - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
